operand_fetch: RTL and testbench

- Register-read / operand-fetch stage of the 64-bit pipelined CPU.
- Sits directly downstream of the 32x64 register file (X31 hardwired to zero) and upstream of the ALU.
- Drives the register-file read addresses, resolves RAW hazards by forwarding from EX/MEM/WB, and detects load-use hazards (stall + bubble).
- Registers the resolved operands into the ID/EX pipeline register.

---
 rtl/operand_fetch_if.sv | 77 +++++++
 rtl/operand_fetch.sv | 129 ++++++++++++
 tb/tb_operand_fetch.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/operand_fetch_if.sv
// Operand-fetch bundle: decode inputs, regfile read ports, EX/MEM/WB bypass sources, ID/EX outputs.
// Carries no state; timing is set by the operand_fetch stage that owns the slave side.
// stall flows back to the upstream producer on the same bundle (combinational).
interface operand_fetch_if #(
    parameter int WIDTH   = 64,
    parameter int REGBITS = 5
);
    // decoded instruction
    logic               in_valid;
    logic [REGBITS-1:0] in_rn;
    logic [REGBITS-1:0] in_rm;
    logic               in_use_rn;
    logic               in_use_rm;
    logic [REGBITS-1:0] in_rd;
    logic               in_reg_write;
    logic               in_mem_read;
    logic               flush;

    // register file read ports
    logic [REGBITS-1:0] rf_rr1;
    logic [REGBITS-1:0] rf_rr2;
    logic [WIDTH-1:0]   rf_rd1;
    logic [WIDTH-1:0]   rf_rd2;

    // EX stage status
    logic               ex_valid;
    logic               ex_reg_write;
    logic               ex_mem_read;
    logic [REGBITS-1:0] ex_rd;
    logic [WIDTH-1:0]   ex_result;

    // MEM stage status
    logic               mem_valid;
    logic               mem_reg_write;
    logic [REGBITS-1:0] mem_rd;
    logic [WIDTH-1:0]   mem_result;

    // WB stage (shared with the regfile write port)
    logic               wb_reg_write;
    logic [REGBITS-1:0] wb_rd;
    logic [WIDTH-1:0]   wb_data;

    // upstream hold request
    logic               stall;

    // ID/EX pipeline register
    logic               out_valid;
    logic               out_reg_write;
    logic               out_mem_read;
    logic [REGBITS-1:0] out_rd;
    logic [WIDTH-1:0]   out_a;
    logic [WIDTH-1:0]   out_b;

    // pipeline environment side (decode, regfile, later stages)
    modport master (
        output in_valid, in_rn, in_rm, in_use_rn, in_use_rm, in_rd,
               in_reg_write, in_mem_read, flush,
        output rf_rd1, rf_rd2,
        output ex_valid, ex_reg_write, ex_mem_read, ex_rd, ex_result,
        output mem_valid, mem_reg_write, mem_rd, mem_result,
        output wb_reg_write, wb_rd, wb_data,
        input  rf_rr1, rf_rr2, stall,
        input  out_valid, out_reg_write, out_mem_read, out_rd, out_a, out_b
    );

    // operand-fetch stage side
    modport slave (
        input  in_valid, in_rn, in_rm, in_use_rn, in_use_rm, in_rd,
               in_reg_write, in_mem_read, flush,
        input  rf_rd1, rf_rd2,
        input  ex_valid, ex_reg_write, ex_mem_read, ex_rd, ex_result,
        input  mem_valid, mem_reg_write, mem_rd, mem_result,
        input  wb_reg_write, wb_rd, wb_data,
        output rf_rr1, rf_rr2, stall,
        output out_valid, out_reg_write, out_mem_read, out_rd, out_a, out_b
    );
endinterface

// File: rtl/operand_fetch.sv
// Register-read stage: regfile addressing, EX/MEM/WB operand bypass, load-use hazard detection into ID/EX.
// Latency 1 cycle; a load-use hazard inserts exactly one bubble while stall holds the instruction upstream.
// Backpressure: combinational stall to upstream; downstream is never stalled. Optional stall_count via OPERAND_FETCH_STALL_CNT_EN.
module operand_fetch #(
    parameter int WIDTH    = 64,
    parameter int REGBITS  = 5,
    parameter int ZERO_REG = 31
) (
    input  logic clk,
    input  logic reset,
    operand_fetch_if.slave bus
`ifdef OPERAND_FETCH_STALL_CNT_EN
    ,
    output logic [31:0] stall_count
`endif
);

    localparam logic [REGBITS-1:0] ZERO_IDX = REGBITS'(ZERO_REG);

    logic             exFwdOk;
    logic             memFwdOk;
    logic             wbFwdOk;
    logic             loadInEx;
    logic             hazard;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;

    // Pick the youngest in-flight producer for one source; X31 always reads as zero.
    function automatic logic [WIDTH-1:0] resolveOperand(
        input logic [REGBITS-1:0] src,
        input logic [WIDTH-1:0]   rfData,
        input logic               exOk,
        input logic [REGBITS-1:0] exRd,
        input logic [WIDTH-1:0]   exResult,
        input logic               memOk,
        input logic [REGBITS-1:0] memRd,
        input logic [WIDTH-1:0]   memResult,
        input logic               wbOk,
        input logic [REGBITS-1:0] wbRd,
        input logic [WIDTH-1:0]   wbData
    );
        logic [WIDTH-1:0] result;
        result = rfData;
        if (src == ZERO_IDX) begin
            result = '0;
        end else if (exOk && (exRd == src)) begin
            result = exResult;
        end else if (memOk && (memRd == src)) begin
            result = memResult;
        end else if (wbOk && (wbRd == src)) begin
            // regfile write lands on the same edge, so its read port still shows the old value
            result = wbData;
        end
        return result;
    endfunction

    // Regfile addresses come straight from the decoded sources.
    assign bus.rf_rr1 = bus.in_rn;
    assign bus.rf_rr2 = bus.in_rm;

    // Bypass qualifiers: a load in EX has no data yet, so it is never a bypass source.
    always_comb begin
        exFwdOk  = bus.ex_valid & bus.ex_reg_write & ~bus.ex_mem_read;
        memFwdOk = bus.mem_valid & bus.mem_reg_write;
        wbFwdOk  = bus.wb_reg_write;
        loadInEx = bus.ex_valid & bus.ex_mem_read & bus.ex_reg_write & (bus.ex_rd != ZERO_IDX);
    end

    // Load-use hazard: a used source depends on a load still in EX.
    always_comb begin
        hazard = bus.in_valid & loadInEx &
                 ((bus.in_use_rn & (bus.ex_rd == bus.in_rn)) |
                  (bus.in_use_rm & (bus.ex_rd == bus.in_rm)));
    end

    // A flush discards the instruction anyway, so holding it upstream would be pointless.
    assign bus.stall = hazard & ~bus.flush & ~reset;

    // Resolve both operands every cycle, whether or not the source is used.
    always_comb begin
        opA = resolveOperand(bus.in_rn, bus.rf_rd1,
                             exFwdOk, bus.ex_rd, bus.ex_result,
                             memFwdOk, bus.mem_rd, bus.mem_result,
                             wbFwdOk, bus.wb_rd, bus.wb_data);
        opB = resolveOperand(bus.in_rm, bus.rf_rd2,
                             exFwdOk, bus.ex_rd, bus.ex_result,
                             memFwdOk, bus.mem_rd, bus.mem_result,
                             wbFwdOk, bus.wb_rd, bus.wb_data);
    end

    // ID/EX register: reset clears, flush/hazard load a bubble, otherwise capture the instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid     <= 1'b0;
            bus.out_reg_write <= 1'b0;
            bus.out_mem_read  <= 1'b0;
            bus.out_rd        <= '0;
            bus.out_a         <= '0;
            bus.out_b         <= '0;
        end else if (bus.flush || hazard) begin
            bus.out_valid     <= 1'b0;
            bus.out_reg_write <= 1'b0;
            bus.out_mem_read  <= 1'b0;
            bus.out_rd        <= ZERO_IDX;
            bus.out_a         <= '0;
            bus.out_b         <= '0;
        end else begin
            bus.out_valid     <= bus.in_valid;
            bus.out_reg_write <= bus.in_valid & bus.in_reg_write;
            bus.out_mem_read  <= bus.in_valid & bus.in_mem_read;
            bus.out_rd        <= bus.in_rd;
            bus.out_a         <= opA;
            bus.out_b         <= opB;
        end
    end

`ifdef OPERAND_FETCH_STALL_CNT_EN
    // Free-running count of stall cycles; wraps naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
        end else if (bus.stall) begin
            stall_count <= stall_count + 32'd1;
        end
    end
`else
`endif

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    operand_fetch_if #(.WIDTH(64), .REGBITS(5)) bus ();

`ifdef OPERAND_FETCH_STALL_CNT_EN
    logic [31:0] stallCount;
    operand_fetch #(.WIDTH(64), .REGBITS(5), .ZERO_REG(31)) dut (
        .clk(clk), .reset(reset), .bus(bus), .stall_count(stallCount));
`else
    operand_fetch #(.WIDTH(64), .REGBITS(5), .ZERO_REG(31)) dut (
        .clk(clk), .reset(reset), .bus(bus));
`endif

    // Register file model: X31 reads as zero.
    logic [63:0] rf [32];
    assign bus.rf_rd1 = (bus.rf_rr1 == 5'd31) ? 64'd0 : rf[bus.rf_rr1];
    assign bus.rf_rd2 = (bus.rf_rr2 == 5'd31) ? 64'd0 : rf[bus.rf_rr2];

    typedef struct {
        logic        valid;
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic        useRn;
        logic        useRm;
        logic [4:0]  rd;
        logic        regWr;
        logic        ld;
        logic        fl;
        logic        exV;
        logic        exW;
        logic        exM;
        logic [4:0]  exRd;
        logic [63:0] exRes;
        logic        mV;
        logic        mW;
        logic [4:0]  mRd;
        logic [63:0] mRes;
        logic        wW;
        logic [4:0]  wRd;
        logic [63:0] wD;
        logic        eStall;
        logic        eValid;
        logic        eRegWr;
        logic        eLd;
        logic [4:0]  eRd;
        logic [63:0] eA;
        logic [63:0] eB;
    } vec_t;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.in_valid      = v.valid;
        bus.in_rn         = v.rn;
        bus.in_rm         = v.rm;
        bus.in_use_rn     = v.useRn;
        bus.in_use_rm     = v.useRm;
        bus.in_rd         = v.rd;
        bus.in_reg_write  = v.regWr;
        bus.in_mem_read   = v.ld;
        bus.flush         = v.fl;
        bus.ex_valid      = v.exV;
        bus.ex_reg_write  = v.exW;
        bus.ex_mem_read   = v.exM;
        bus.ex_rd         = v.exRd;
        bus.ex_result     = v.exRes;
        bus.mem_valid     = v.mV;
        bus.mem_reg_write = v.mW;
        bus.mem_rd        = v.mRd;
        bus.mem_result    = v.mRes;
        bus.wb_reg_write  = v.wW;
        bus.wb_rd         = v.wRd;
        bus.wb_data       = v.wD;
    endtask

    // Drive at negedge, check stall/addresses before the edge, registered outputs just after it.
    task automatic runVec(input string tag, input vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        chk({tag, ".stall"}, 64'(bus.stall), 64'(v.eStall));
        chk({tag, ".rr1"}, 64'(bus.rf_rr1), 64'(v.rn));
        chk({tag, ".rr2"}, 64'(bus.rf_rr2), 64'(v.rm));
        @(posedge clk);
        #1;
        chk({tag, ".outValid"}, 64'(bus.out_valid), 64'(v.eValid));
        chk({tag, ".outRegWr"}, 64'(bus.out_reg_write), 64'(v.eRegWr));
        chk({tag, ".outMemRd"}, 64'(bus.out_mem_read), 64'(v.eLd));
        chk({tag, ".outRd"}, 64'(bus.out_rd), 64'(v.eRd));
        chk({tag, ".outA"}, bus.out_a, v.eA);
        chk({tag, ".outB"}, bus.out_b, v.eB);
    endtask

    vec_t vecs [14];
    vec_t hv;

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 64'h1000 + 64'(i);
        rf[3] = 64'h5;

        // fields: valid,rn,rm,uRn,uRm,rd,rw,ld,fl, exV,exW,exM,exRd,exRes, mV,mW,mRd,mRes, wW,wRd,wD, eStall,eV,eRW,eLd,eRd,eA,eB
        // regfile path, rm = X31
        vecs[0]  = '{1,3,31,1,1,5,1,0,0,  0,0,0,0,0,         0,0,0,0,            0,0,0,          0,1,1,0,5,64'h5,0};
        // all three bypass sources hit rn: EX wins
        vecs[1]  = '{1,4,6,1,1,10,1,0,0,  1,1,0,4,64'hA,     1,1,4,64'hB,        1,4,64'hC,      0,1,1,0,10,64'hA,64'h1006};
        // EX not valid: MEM wins
        vecs[2]  = '{1,4,6,1,1,10,1,0,0,  0,1,0,4,64'hA,     1,1,4,64'hB,        1,4,64'hC,      0,1,1,0,10,64'hB,64'h1006};
        // EX and MEM not valid: WB wins
        vecs[3]  = '{1,4,6,1,1,10,1,0,0,  0,1,0,4,64'hA,     0,1,4,64'hB,        1,4,64'hC,      0,1,1,0,10,64'hC,64'h1006};
        // X31 source with an EX load to X31: zero operand, no stall
        vecs[4]  = '{1,31,2,1,1,11,1,0,0, 1,1,1,31,64'hFF,   0,0,0,0,            0,0,0,          0,1,1,0,11,0,64'h1002};
        // EX load matches an unused rn: no stall, no EX bypass of a load
        vecs[5]  = '{1,7,2,0,1,12,1,0,0,  1,1,1,7,64'h55,    0,0,0,0,            0,0,0,          0,1,1,0,12,64'h1007,64'h1002};
        // in_valid=0 with load-use pattern: no stall, non-valid registered
        vecs[6]  = '{0,7,8,1,1,9,1,1,0,   1,1,1,7,64'h55,    0,0,0,0,            0,0,0,          0,0,0,0,9,64'h1007,64'h1008};
        // load-use through rm: stall + bubble
        vecs[7]  = '{1,2,7,1,1,13,1,0,0,  1,1,1,7,64'h55,    0,0,0,0,            0,0,0,          1,0,0,0,31,0,0};
        // MEM match without reg_write: regfile used
        vecs[8]  = '{1,2,3,1,1,14,1,0,0,  0,0,0,0,0,         1,0,2,64'hBEEF,     0,0,0,          0,1,1,0,14,64'h1002,64'h5};
        // WB bypass on rm, load instruction passes mem_read through
        vecs[9]  = '{1,1,8,1,1,15,1,1,0,  0,0,0,0,0,         0,0,0,0,            1,8,64'hDEAD,   0,1,1,1,15,64'h1001,64'hDEAD};
        // plain flush: bubble
        vecs[10] = '{1,4,5,1,1,16,1,0,1,  1,1,0,4,64'hA,     0,0,0,0,            0,0,0,          0,0,0,0,31,0,0};
        // EX without reg_write is skipped, MEM supplies; in_reg_write=0
        vecs[11] = '{1,5,6,1,1,17,0,0,0,  1,0,0,5,64'h77,    1,1,5,64'h88,       0,0,0,          0,1,0,0,17,64'h88,64'h1006};
        // WB to X31 never forwarded
        vecs[12] = '{1,6,31,1,1,18,1,0,0, 0,0,0,0,0,         0,0,0,0,            1,31,64'h99,    0,1,1,0,18,64'h1006,0};
        // EX load skipped, MEM bypass of the same register (unused rn, no stall)
        vecs[13] = '{1,9,2,0,1,19,1,0,0,  1,1,1,9,64'h55,    1,1,9,64'h4242,     0,0,0,          0,1,1,0,19,64'h4242,64'h1002};

        // Reset for two cycles with a load-use pattern present: outputs zero, stall suppressed.
        reset = 1'b1;
        hv = '{1,3,3,1,0,3,1,0,0, 1,1,1,3,64'h55, 0,0,0,0, 0,0,0, 0,0,0,0,0,0,0};
        runVec("rst0", hv);
        runVec("rst1", hv);
        // First edge out of reset registers the instruction normally.
        reset = 1'b0;
        hv = '{1,3,3,1,0,3,1,0,0, 0,1,1,3,64'h55, 0,0,0,0, 0,0,0, 0,1,1,0,3,64'h5,64'h5};
        runVec("rstRel", hv);
`ifdef OPERAND_FETCH_STALL_CNT_EN
        chk("cnt.afterReset", 64'(stallCount), 64'd0);
`endif

        // Load-use on rn: one stall with bubble, then MEM forwarding of the load.
        hv = '{1,7,2,1,1,20,1,0,0, 1,1,1,7,64'h55, 0,0,0,0, 0,0,0, 1,0,0,0,31,0,0};
        runVec("ldUse1", hv);
`ifdef OPERAND_FETCH_STALL_CNT_EN
        chk("cnt.afterLoadUse", 64'(stallCount), 64'd1);
`endif
        hv = '{1,7,2,1,1,20,1,0,0, 0,0,0,0,0, 1,1,7,64'h1234, 0,0,0, 0,1,1,0,20,64'h1234,64'h1002};
        runVec("ldUse2", hv);

        // Flush beats hazard: no stall, bubble; next instruction proceeds without stall.
        hv = '{1,7,2,1,1,21,1,0,1, 1,1,1,7,64'h55, 0,0,0,0, 0,0,0, 0,0,0,0,31,0,0};
        runVec("flushHaz1", hv);
        hv = '{1,7,2,1,1,21,1,0,0, 0,0,0,0,0, 0,0,0,0, 0,0,0, 0,1,1,0,21,64'h1007,64'h1002};
        runVec("flushHaz2", hv);

        for (int i = 0; i < 14; i++) begin
            runVec($sformatf("vec%0d", i), vecs[i]);
        end
`ifdef OPERAND_FETCH_STALL_CNT_EN
        chk("cnt.final", 64'(stallCount), 64'd2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
